debounce_bank: RTL and testbench
================================

DEBOUNCE_BANK -- requirements
Module: debounce_bank

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent input channels (1..16).
REQ-002 Parameter STABLE_TICKS, default 4: consecutive sampled ticks of a new level required before it is accepted (2..255).
REQ-003 Parameter REPEAT_DELAY, default 16: ticks of continuous press before the first auto-repeat pulse (used only with DEBOUNCE_AUTOREPEAT_EN).
REQ-004 Parameter REPEAT_PERIOD, default 8: ticks between subsequent auto-repeat pulses (used only with DEBOUNCE_AUTOREPEAT_EN).
REQ-005 clk  input  1  system clock; all state updates on rising edge.
REQ-006 clearn  input  1  asynchronous, active-low reset.
REQ-007 tick  input  1  sample enable; debounce and repeat counters advance only in cycles with tick=1.
REQ-008 raw_in  input  CHANNELS  asynchronous raw button levels, 1 = pressed.
REQ-009 stable_out  output  CHANNELS  debounced level per channel.
REQ-010 rise_pulse  output  CHANNELS  one-cycle pulse per accepted press.
REQ-011 fall_pulse  output  CHANNELS  one-cycle pulse per accepted release.
REQ-012 repeat_pulse  output  CHANNELS  one-cycle auto-repeat pulse per channel.
REQ-013 any_event  output  1  OR of all rise_pulse, fall_pulse and repeat_pulse bits.

Function
REQ-014 Each raw_in bit SHALL pass through a 2-flop synchronizer before any other use; the synchronizer runs every cycle, independent of tick.
REQ-015 Per channel, a counter of width $clog2(STABLE_TICKS+1) SHALL clear in any tick=1 cycle where the synchronized level equals stable_out.
REQ-016 In a tick=1 cycle where the synchronized level differs from stable_out, the counter SHALL increment; on the STABLE_TICKS-th consecutive such tick, stable_out SHALL toggle and the counter SHALL clear.
REQ-017 A differing level lasting fewer than STABLE_TICKS ticks SHALL leave stable_out unchanged (glitch rejected, counter cleared on return).
REQ-018 With tick=1 every cycle, stable_out SHALL change on the (STABLE_TICKS+2)-th rising edge counting the first edge at which raw_in is captured at its new level.
REQ-019 tick=0 SHALL freeze all debounce and repeat counters and stable_out.
REQ-020 rise_pulse[i]/fall_pulse[i] SHALL be registered and high for exactly the one cycle following the edge on which stable_out[i] goes 0->1 / 1->0.
REQ-021 Channels SHALL be fully independent; simultaneous transitions on several channels SHALL produce simultaneous pulses on each.
REQ-022 any_event SHALL be combinational from the registered pulse outputs (zero added latency).

Reset
REQ-023 clearn=0 SHALL immediately clear synchronizers, counters, stable_out, all pulse outputs and repeat state, including mid-count; no pulse SHALL be generated on reset entry or release.
REQ-024 After clearn rises, a channel held pressed SHALL be debounced as a new press (rise_pulse after STABLE_TICKS ticks).

Configuration
REQ-025 With DEBOUNCE_AUTOREPEAT_EN defined: per channel, a repeat counter counts ticks while stable_out[i]=1, pulses repeat_pulse[i] after REPEAT_DELAY ticks, then every REPEAT_PERIOD ticks while held; it clears when stable_out[i]=0 (no pulse after release).
REQ-026 Without DEBOUNCE_AUTOREPEAT_EN: no repeat counters are synthesized; repeat_pulse SHALL be constant 0 and REPEAT_DELAY/REPEAT_PERIOD are ignored.

Verification
REQ-027 Defaults, tick=1, raw_in[0] 0->1 held -> stable_out[0]=1 on 6th edge, rise_pulse[0] one cycle next, any_event=1 same cycle.
REQ-028 raw_in[1] high for 3 ticks then low -> stable_out, rise_pulse, fall_pulse all stay 0.
REQ-029 tick every 4th cycle, raw_in[2] pressed -> stable_out[2] rises only after 4 ticks; frozen between ticks.
REQ-030 raw_in=4'b1111 simultaneously, clearn pulsed low after 2 ticks -> all outputs 0 at once; press re-accepted 4 ticks after release of reset.
REQ-031 Macro defined, raw_in[3] held 40 ticks -> repeat_pulse[3] at ticks 16, 24, 32, 40 after stable press; none after release. Macro undefined -> repeat_pulse always 0.

Source files
------------

// File: rtl/debounce_bank.sv
// Bank of independent push-button debouncers with edge pulses and an optional auto-repeat.
// Optional feature: define DEBOUNCE_AUTOREPEAT_EN to build the per-channel auto-repeat counters.
module debounce_bank #(
  parameter int CHANNELS      = 4,
  parameter int STABLE_TICKS  = 4,
  parameter int REPEAT_DELAY  = 16,
  parameter int REPEAT_PERIOD = 8
) (
  input  logic                clk,
  input  logic                clearn,
  input  logic                tick,
  input  logic [CHANNELS-1:0] raw_in,
  output logic [CHANNELS-1:0] stable_out,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse,
  output logic [CHANNELS-1:0] repeat_pulse,
  output logic                any_event
);

  localparam int CW = $clog2(STABLE_TICKS + 1);

  logic [CHANNELS-1:0] r_sync1;
  logic [CHANNELS-1:0] r_sync2;
  logic [CHANNELS-1:0] r_stable;
  logic [CHANNELS-1:0] r_rise;
  logic [CHANNELS-1:0] r_fall;
  logic [CW-1:0]       r_cnt [CHANNELS];
  logic [CHANNELS-1:0] w_toggle;
  logic [CHANNELS-1:0] w_stable_nxt;

  // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= raw_in;
      r_sync2 <= r_sync1;
    end
  end

  // A channel toggles on the tick that completes STABLE_TICKS consecutive differing samples.
  always_comb begin
    w_toggle = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_toggle[i] = tick && (r_sync2[i] != r_stable[i]) && (r_cnt[i] == CW'(STABLE_TICKS - 1));
    end
    w_stable_nxt = r_stable ^ w_toggle;
  end

  // NOTE: the counter array is only CHANNELS small registers, so it is reset like any other state.
  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      r_stable <= '0;
      r_rise   <= '0;
      r_fall   <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_rise <= w_toggle & ~r_stable;
      r_fall <= w_toggle & r_stable;
      for (int i = 0; i < CHANNELS; i++) begin
        if (tick) begin
          if (r_sync2[i] == r_stable[i]) begin
            r_cnt[i] <= '0;
          end else if (w_toggle[i]) begin
            r_cnt[i]    <= '0;
            r_stable[i] <= ~r_stable[i];
          end else begin
            r_cnt[i] <= r_cnt[i] + CW'(1);
          end
        end
      end
    end
  end

`ifdef DEBOUNCE_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY + 1);

  logic [RW-1:0]       r_rpt_cnt [CHANNELS];
  logic [CHANNELS-1:0] r_repeat;

  // After the first pulse the counter restarts part-way so later pulses come every REPEAT_PERIOD ticks.
  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      r_repeat <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        r_rpt_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (!w_stable_nxt[i]) begin
          r_rpt_cnt[i] <= '0;
          r_repeat[i]  <= 1'b0;
        end else if (tick && r_stable[i]) begin
          if (r_rpt_cnt[i] == RW'(REPEAT_DELAY - 1)) begin
            r_rpt_cnt[i] <= RW'(REPEAT_DELAY - REPEAT_PERIOD);
            r_repeat[i]  <= 1'b1;
          end else begin
            r_rpt_cnt[i] <= r_rpt_cnt[i] + RW'(1);
            r_repeat[i]  <= 1'b0;
          end
        end else begin
          r_repeat[i] <= 1'b0;
        end
      end
    end
  end

  assign repeat_pulse = r_repeat;
`else
  localparam int unused_rpt_cfg = REPEAT_DELAY + REPEAT_PERIOD;

  assign repeat_pulse = '0;
`endif

  assign stable_out = r_stable;
  assign rise_pulse = r_rise;
  assign fall_pulse = r_fall;
  assign any_event  = |(r_rise | r_fall | repeat_pulse);

endmodule

// File: tb/tb_debounce_bank.sv
// Directed self-checking bench for debounce_bank (default parameters).
// Repeat expectations follow DEBOUNCE_AUTOREPEAT_EN when it is defined for the build.
module tb_debounce_bank;

  logic       clk;
  logic       clearn;
  logic       tick;
  logic [3:0] raw_in;
  logic [3:0] stable_out;
  logic [3:0] rise_pulse;
  logic [3:0] fall_pulse;
  logic [3:0] repeat_pulse;
  logic       any_event;

  int n_checks = 0;
  int n_err    = 0;

`ifdef DEBOUNCE_AUTOREPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  debounce_bank #(
    .CHANNELS(4),
    .STABLE_TICKS(4),
    .REPEAT_DELAY(16),
    .REPEAT_PERIOD(8)
  ) dut (
    .clk(clk),
    .clearn(clearn),
    .tick(tick),
    .raw_in(raw_in),
    .stable_out(stable_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .repeat_pulse(repeat_pulse),
    .any_event(any_event)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and park on the following falling edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] exp_rep;
    logic       exp_fall;

    clearn = 1'b0;
    tick   = 1'b0;
    raw_in = 4'b0000;
    #1;
    check("rst_stable", stable_out, 4'b0000);
    check("rst_pulses", {rise_pulse, fall_pulse, repeat_pulse}, 12'h000);
    check("rst_any", any_event, 1'b0);
    cyc(2);
    clearn = 1'b1;
    tick   = 1'b1;

    // Basic press on channel 0: accepted on the 6th edge.
    raw_in = 4'b0001;
    cyc(5);
    check("press_edge5_stable", stable_out, 4'b0000);
    cyc(1);
    check("press_edge6_stable", stable_out, 4'b0001);
    check("press_rise", rise_pulse, 4'b0001);
    check("press_fall", fall_pulse, 4'b0000);
    check("press_any", any_event, 1'b1);
    cyc(1);
    check("press_rise_gone", rise_pulse, 4'b0000);
    check("press_any_gone", any_event, 1'b0);
    check("press_hold", stable_out, 4'b0001);

    // Three-tick glitch on channel 1 is rejected.
    raw_in = 4'b0011;
    cyc(3);
    raw_in = 4'b0001;
    for (int k = 0; k < 6; k++) begin
      cyc(1);
      check("glitch", {stable_out, rise_pulse, fall_pulse}, {4'b0001, 8'h00});
    end

    // Sparse tick (every 4th cycle): channel 2 accepted on its 4th tick only.
    raw_in = 4'b0101;
    tick   = 1'b0;
    for (int k = 0; k <= 16; k++) begin
      tick = ((k % 4) == 3);
      cyc(1);
      if (k == 8)  check("sparse_k8_stable", stable_out, 4'b0001);
      if (k == 14) check("sparse_k14_stable", stable_out, 4'b0001);
      if (k == 15) begin
        check("sparse_k15_stable", stable_out, 4'b0101);
        check("sparse_k15_rise", rise_pulse, 4'b0100);
      end
      if (k == 16) begin
        check("sparse_k16_stable", stable_out, 4'b0101);
        check("sparse_k16_rise", rise_pulse, 4'b0000);
      end
    end

    // Release of channel 0.
    tick   = 1'b1;
    raw_in = 4'b0100;
    cyc(5);
    check("release_edge5_stable", stable_out, 4'b0101);
    cyc(1);
    check("release_edge6_stable", stable_out, 4'b0100);
    check("release_fall", fall_pulse, 4'b0001);
    check("release_rise", rise_pulse, 4'b0000);
    check("release_any", any_event, 1'b1);
    cyc(1);
    check("release_fall_gone", fall_pulse, 4'b0000);

    // Reset mid-count with all channels pressed, then re-acceptance.
    raw_in = 4'b1111;
    cyc(4);
    clearn = 1'b0;
    #1;
    check("midrst_stable", stable_out, 4'b0000);
    check("midrst_pulses", {rise_pulse, fall_pulse, repeat_pulse}, 12'h000);
    check("midrst_any", any_event, 1'b0);
    cyc(2);
    check("midrst_hold_stable", stable_out, 4'b0000);
    check("midrst_hold_fall", fall_pulse, 4'b0000);
    clearn = 1'b1;
    cyc(1);
    check("postrst_rise_none", rise_pulse, 4'b0000);
    cyc(4);
    check("postrst_edge5_stable", stable_out, 4'b0000);
    cyc(1);
    check("postrst_edge6_stable", stable_out, 4'b1111);
    check("postrst_rise", rise_pulse, 4'b1111);
    check("postrst_any", any_event, 1'b1);
    cyc(1);
    check("postrst_rise_gone", rise_pulse, 4'b0000);

    raw_in = 4'b0000;
    cyc(5);
    check("allrel_edge5_stable", stable_out, 4'b1111);
    cyc(1);
    check("allrel_stable", stable_out, 4'b0000);
    check("allrel_fall", fall_pulse, 4'b1111);

    // Long hold on channel 3: auto-repeat (if built) at ticks 16, 24, 32, 40; none after release.
    raw_in = 4'b1000;
    cyc(5);
    check("hold_edge5_stable", stable_out, 4'b0000);
    cyc(1);
    check("hold_stable", stable_out, 4'b1000);
    check("hold_rise", rise_pulse, 4'b1000);
    for (int t = 1; t <= 60; t++) begin
      cyc(1);
      exp_rep  = (REP_EN && t >= 16 && t <= 40 && ((t - 16) % 8) == 0) ? 4'b1000 : 4'b0000;
      exp_fall = (t == 41);
      check($sformatf("repeat_t%0d", t), repeat_pulse, exp_rep);
      check($sformatf("repeat_any_t%0d", t), any_event, (exp_rep != 4'b0000) || exp_fall);
      if (t == 40) check("hold_t40_stable", stable_out, 4'b1000);
      if (t == 41) begin
        check("hold_t41_stable", stable_out, 4'b0000);
        check("hold_t41_fall", fall_pulse, 4'b1000);
      end
      if (t == 35) raw_in = 4'b0000;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
